// File: rtl/opsel_fwd_stage.sv
// Registered operand-select stage between decode and execute: operand muxing, result
// forwarding, load-use stall and stall-cycle counter. Define OPSEL_FWD_EN to enable forwarding.

`ifndef OP_TYPE_NONE
`define OP_TYPE_NONE 2'd0
`endif
`ifndef OP_TYPE_REG
`define OP_TYPE_REG 2'd1
`endif
`ifndef OP_TYPE_IMM
`define OP_TYPE_IMM 2'd2
`endif
`ifndef OP_TYPE_PC
`define OP_TYPE_PC 2'd3
`endif

module opsel_fwd_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NFWD = 2,
  parameter int unsigned CNTW = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_op1_type,
  input  logic [1:0]             in_op2_type,
  input  logic [4:0]             in_rs1_addr,
  input  logic [4:0]             in_rs2_addr,
  input  logic [XLEN-1:0]        in_rs1_data,
  input  logic [XLEN-1:0]        in_rs2_data,
  input  logic [XLEN-1:0]        in_imm,
  input  logic [XLEN-1:0]        in_pc,
  input  logic [5:0]             in_alucode,
  input  logic [NFWD-1:0]        fwd_valid,
  input  logic [NFWD-1:0]        fwd_pending,
  input  logic [5*NFWD-1:0]      fwd_rd,
  input  logic [XLEN*NFWD-1:0]   fwd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_op1,
  output logic [XLEN-1:0]        out_op2,
  output logic [XLEN-1:0]        out_rs2_val,
  output logic [XLEN-1:0]        out_imm,
  output logic [XLEN-1:0]        out_pc,
  output logic [5:0]             out_alucode,
  output logic [CNTW-1:0]        stall_cnt
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e state_q, state_d;

  logic [XLEN-1:0] rs1_fwd, rs2_fwd, rs1_val, rs2_val, op1_sel, op2_sel;
  logic            rs1_pend, rs2_pend, hazard, transfer;
  logic [XLEN-1:0] op1_q, op2_q, rs2v_q, imm_q, pc_q;
  logic [5:0]      alucode_q;
  logic [CNTW-1:0] stall_q, stall_d;

`ifndef OPSEL_FWD_EN
  logic unused_fwd;
  assign unused_fwd = ^{fwd_data, fwd_pending};
`endif

  // Walk from oldest to youngest so the lowest matching index wins.
  always_comb begin
    rs1_fwd  = in_rs1_data;
    rs2_fwd  = in_rs2_data;
    rs1_pend = 1'b0;
    rs2_pend = 1'b0;
    for (int i = int'(NFWD) - 1; i >= 0; i--) begin
      if (fwd_valid[i] && fwd_rd[5*i +: 5] == in_rs1_addr) begin
`ifdef OPSEL_FWD_EN
        rs1_fwd  = fwd_data[XLEN*i +: XLEN];
        rs1_pend = fwd_pending[i];
`else
        rs1_pend = 1'b1;
`endif
      end
      if (fwd_valid[i] && fwd_rd[5*i +: 5] == in_rs2_addr) begin
`ifdef OPSEL_FWD_EN
        rs2_fwd  = fwd_data[XLEN*i +: XLEN];
        rs2_pend = fwd_pending[i];
`else
        rs2_pend = 1'b1;
`endif
      end
    end
    rs1_val = (in_rs1_addr == 5'd0) ? '0 : rs1_fwd;
    rs2_val = (in_rs2_addr == 5'd0) ? '0 : rs2_fwd;
  end

  always_comb begin
    case (in_op1_type)
      `OP_TYPE_REG: op1_sel = rs1_val;
      `OP_TYPE_IMM: op1_sel = in_imm;
      `OP_TYPE_PC:  op1_sel = in_pc;
      default:      op1_sel = '0;
    endcase
    case (in_op2_type)
      `OP_TYPE_REG: op2_sel = rs2_val;
      `OP_TYPE_IMM: op2_sel = in_imm;
      `OP_TYPE_PC:  op2_sel = in_pc;
      default:      op2_sel = '0;
    endcase
  end

  // rs2 always feeds out_rs2_val, so it is checked regardless of op2 type.
  assign hazard = (in_op1_type == `OP_TYPE_REG && in_rs1_addr != 5'd0 && rs1_pend) ||
                  (in_rs2_addr != 5'd0 && rs2_pend);

  assign out_valid = (state_q == StFull);
  assign in_ready  = !flush && !hazard && (!out_valid || out_ready);
  assign transfer  = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    stall_d = stall_q;
    if (flush) begin
      state_d = StEmpty;
    end else if (transfer) begin
      state_d = StFull;
    end else if (state_q == StFull && out_ready) begin
      state_d = StEmpty;
    end
    if (in_valid && hazard && !flush && stall_q != {CNTW{1'b1}}) begin
      stall_d = stall_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StEmpty;
      stall_q   <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      rs2v_q    <= '0;
      imm_q     <= '0;
      pc_q      <= '0;
      alucode_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      if (transfer) begin
        op1_q     <= op1_sel;
        op2_q     <= op2_sel;
        rs2v_q    <= rs2_val;
        imm_q     <= in_imm;
        pc_q      <= in_pc;
        alucode_q <= in_alucode;
      end
    end
  end

  assign out_op1     = op1_q;
  assign out_op2     = op2_q;
  assign out_rs2_val = rs2v_q;
  assign out_imm     = imm_q;
  assign out_pc      = pc_q;
  assign out_alucode = alucode_q;
  assign stall_cnt   = stall_q;

endmodule
